// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and the
// parity-type constants used by uart_rx / uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_START,
    ARB_WAIT_ACK,
    ARB_WAIT_DONE,
    ARB_HOLD
  } arb_state_t;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first set request at or
// above ptr, wrapping modulo N.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan farthest-first so the nearest match wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the single uart_tx, with per-packet
// grant locking via req_last.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_BITS = 8,
  localparam int GW        = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_start,
  output logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_busy,
  output logic [GW-1:0]                grant_id,
  output logic                         active
);

  arb_state_t state, state_nx;

  logic [GW-1:0]        rr_ptr;
  logic [GW-1:0]        grant_q;
  logic                 lock;
  logic [DATA_BITS-1:0] data_q;
  logic                 act_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [GW-1:0]      arb_idx;
  logic               arb_any;

  logic          capture;
  logic          release_gr;
  logic [GW-1:0] cap_id;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    tx_start   = 1'b0;
    capture    = 1'b0;
    release_gr = 1'b0;
    cap_id     = grant_q;
    unique case (state)
      ARB_IDLE: begin
        req_ready = arb_grant;
        cap_id    = arb_idx;
        if (arb_any) begin
          capture  = 1'b1;
          state_nx = ARB_START;
        end
      end
      ARB_START: begin
        tx_start = 1'b1;
        state_nx = ARB_WAIT_ACK;
      end
      ARB_WAIT_ACK: begin
        if (tx_busy) state_nx = ARB_WAIT_DONE;
      end
      ARB_WAIT_DONE: begin
        if (!tx_busy) begin
          if (lock) begin
            state_nx = ARB_HOLD;
          end else begin
            state_nx   = ARB_IDLE;
            release_gr = 1'b1;
          end
        end
      end
      // Owner keeps ready even while it has nothing to send.
      ARB_HOLD: begin
        req_ready[grant_q] = 1'b1;
        if (req_valid[grant_q]) begin
          capture  = 1'b1;
          state_nx = ARB_START;
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      rr_ptr  <= '0;
      lock    <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      act_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (capture) begin
        data_q  <= req_data[int'(cap_id)*DATA_BITS +: DATA_BITS];
        grant_q <= cap_id;
        act_q   <= 1'b1;
        lock    <= ~req_last[cap_id];
      end
      if (release_gr) begin
        act_q  <= 1'b0;
        rr_ptr <= (grant_q == GW'(NUM_REQ - 1)) ? '0
                                                : grant_q + GW'(1);
      end
    end
  end

  assign tx_data  = data_q;
  assign grant_id = grant_q;
  assign active   = act_q;

endmodule
